// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file, one write port, two combinational
// read ports, write-to-read bypass, per-register pending scoreboard and a
// post-reset clearing sweep (ready rises once every register holds zero).
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   w, wa, wd          write enable / address / data
//   raA/rdA, raB/rdB   read address / combinational read data, ports A and B
//   mark, ma           set pending bit of register ma
//   pendA, pendB       register at raA / raB still has a result in flight
//   ready              clearing sweep complete, file usable
module regfile_sb #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned AW      = 3,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    raA,
  output logic [WIDTH-1:0] rdA,
  input  logic [AW-1:0]    raB,
  output logic [WIDTH-1:0] rdB,
  input  logic             mark,
  input  logic [AW-1:0]    ma,
  output logic             pendA,
  output logic             pendB,
  output logic             ready
);

  // Index width of the implemented array; addresses are range-checked first.
  localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic run;
  logic out_en;
  logic wr_ok;
  logic mk_ok;
  logic okA;
  logic okB;
  logic bypA;
  logic bypB;

  // Address names an implemented, writable/readable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (32'(a) < NREGS) && !(ZERO_R0 && (a == '0));
  endfunction

  assign run    = (state_q == ST_RUN);
  assign out_en = run && rst_n;
  assign wr_ok  = run && w && addr_ok(wa);
  assign mk_ok  = run && mark && addr_ok(ma);

  // Scoreboard update: a write retires its register, a mark applied after it
  // so a same-cycle re-mark (newer producer) leaves the register pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[IW'(wa)] = 1'b0;
    if (mk_ok) pend_d[IW'(ma)] = 1'b1;
  end

  // Control FSM: sweep counter, state and scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREGS - 1)) state_q <= ST_RUN;
        end
        default: ;
      endcase
    end
  end

  // Storage array, not reset: cleared by the sweep, then written by port W.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_INIT) regs_q[IW'(cnt_q)] <= '0;
      else if (wr_ok)         regs_q[IW'(wa)]    <= wd;
    end
  end

  // Read ports: zero for invalid/zero addresses, same-cycle write bypassed.
  assign okA  = addr_ok(raA);
  assign okB  = addr_ok(raB);
  assign bypA = wr_ok && (wa == raA);
  assign bypB = wr_ok && (wa == raB);

  assign rdA   = (out_en && okA) ? (bypA ? wd : regs_q[IW'(raA)]) : '0;
  assign rdB   = (out_en && okB) ? (bypB ? wd : regs_q[IW'(raB)]) : '0;
  assign pendA = out_en && okA && pend_q[IW'(raA)] && !bypA;
  assign pendB = out_en && okB && pend_q[IW'(raB)] && !bypB;
  assign ready = out_en;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: an 8-register and a 6-register instance share one
// stimulus stream; a directed table checks the 8-register file against fixed
// values, and every cycle both are compared with an array-based model.
module tb_regfile_sb;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          w = 1'b0;
  logic          mark = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] raA = '0;
  logic [AW-1:0] raB = '0;
  logic [AW-1:0] ma = '0;
  logic [W-1:0]  wd = '0;

  logic [W-1:0] rdA8, rdB8, rdA6, rdB6;
  logic         pendA8, pendB8, ready8, pendA6, pendB6, ready6;

  regfile_sb #(.WIDTH(W), .NREGS(8), .AW(AW), .ZERO_R0(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .w(w), .wa(wa), .wd(wd),
    .raA(raA), .rdA(rdA8), .raB(raB), .rdB(rdB8),
    .mark(mark), .ma(ma), .pendA(pendA8), .pendB(pendB8), .ready(ready8)
  );

  regfile_sb #(.WIDTH(W), .NREGS(6), .AW(AW), .ZERO_R0(1'b1)) dut6 (
    .clk(clk), .rst_n(rst_n), .w(w), .wa(wa), .wd(wd),
    .raA(raA), .rdA(rdA6), .raB(raB), .rdB(rdB6),
    .mark(mark), .ma(ma), .pendA(pendA6), .pendB(pendB6), .ready(ready6)
  );

  typedef struct {
    bit           rst;
    bit           w;
    logic [2:0]   wa;
    logic [W-1:0] wd;
    logic [2:0]   raA;
    logic [2:0]   raB;
    bit           mark;
    logic [2:0]   ma;
    logic [W-1:0] eA;
    bit           ePA;
    logic [W-1:0] eB;
    bit           ePB;
    bit           eR;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays, index 0 = 8-register file, 1 = 6-register.
  logic [W-1:0] m_mem  [2][8];
  bit           m_pend [2][8];
  int           m_swept[2];

  function automatic int nregs(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic bit m_valid(input int k, input int a);
    return (a < nregs(k)) && (a != 0);
  endfunction

  function automatic bit m_ready(input int k);
    return rst_n && (m_swept[k] >= nregs(k));
  endfunction

  function automatic bit m_byp(input int k, input int ra);
    return w && (int'(wa) == ra) && m_valid(k, int'(wa));
  endfunction

  function automatic logic [W-1:0] m_rd(input int k, input int ra);
    if (!m_ready(k) || !m_valid(k, ra)) return '0;
    if (m_byp(k, ra)) return wd;
    return m_mem[k][ra];
  endfunction

  function automatic bit m_pd(input int k, input int ra);
    return m_ready(k) && m_valid(k, ra) && m_pend[k][ra] && !m_byp(k, ra);
  endfunction

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_swept[k] = 0;
        for (int r = 0; r < 8; r++) m_pend[k][r] = 1'b0;
      end else if (m_swept[k] < nregs(k)) begin
        m_mem[k][m_swept[k]] = '0;
        m_swept[k]++;
      end else begin
        if (w && m_valid(k, int'(wa))) begin
          m_mem[k][wa]  = wd;
          m_pend[k][wa] = 1'b0;
        end
        if (mark && m_valid(k, int'(ma))) m_pend[k][ma] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rdA8"},   rdA8,       m_rd(0, int'(raA)));
    chk({tag, " rdB8"},   rdB8,       m_rd(0, int'(raB)));
    chk({tag, " pendA8"}, W'(pendA8), W'(m_pd(0, int'(raA))));
    chk({tag, " pendB8"}, W'(pendB8), W'(m_pd(0, int'(raB))));
    chk({tag, " ready8"}, W'(ready8), W'(m_ready(0)));
    chk({tag, " rdA6"},   rdA6,       m_rd(1, int'(raA)));
    chk({tag, " rdB6"},   rdB6,       m_rd(1, int'(raB)));
    chk({tag, " pendA6"}, W'(pendA6), W'(m_pd(1, int'(raA))));
    chk({tag, " pendB6"}, W'(pendB6), W'(m_pd(1, int'(raB))));
    chk({tag, " ready6"}, W'(ready6), W'(m_ready(1)));
  endtask

  function automatic vec_t mk(input bit rst, input bit wv, input int wav, input int wdv,
                              input int ra, input int rb, input bit mk_v, input int mav,
                              input int eA, input bit ePA, input int eB, input bit ePB,
                              input bit eR);
    vec_t v;
    v.rst = rst;  v.w = wv;  v.wa = 3'(wav);  v.wd = W'(wdv);
    v.raA = 3'(ra);  v.raB = 3'(rb);  v.mark = mk_v;  v.ma = 3'(mav);
    v.eA = W'(eA);  v.ePA = ePA;  v.eB = W'(eB);  v.ePB = ePB;  v.eR = eR;
    return v;
  endfunction

  // Apply one vector in the low phase and compare against the model.
  task automatic drive(input vec_t v, input string tag);
    @(negedge clk);
    rst_n = v.rst;  w = v.w;  wa = v.wa;  wd = v.wd;
    raA = v.raA;  raB = v.raB;  mark = v.mark;  ma = v.ma;
    #2;
    check_model(tag);
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_swept[k] = 0;
      for (int r = 0; r < 8; r++) begin
        m_mem[k][r]  = '0;
        m_pend[k][r] = 1'b0;
      end
    end

    // Reset, then sweep with w/mark active (must be ignored while sweeping).
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (8) tbl.push_back(mk(1, 1, 3, 'hFFFF, 3, 3, 1, 3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, i, i, 0, 0, 0, 0, 0, 0, 1));
    // Basic write/read.
    tbl.push_back(mk(1, 1, 3, 'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 5, 'h1234, 3, 5, 0, 0, 'hBEEF, 0, 'h1234, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 5, 0, 0, 'hBEEF, 0, 'h1234, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 3, 0, 0, 'hBEEF, 0, 'hBEEF, 0, 1));
    // Bypass and zero register.
    tbl.push_back(mk(1, 1, 2, 'hA5A5, 2, 3, 0, 0, 'hA5A5, 0, 'hBEEF, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2, 2, 0, 0, 'hA5A5, 0, 'hA5A5, 0, 1));
    tbl.push_back(mk(1, 1, 0, 'hFFFF, 0, 2, 0, 0, 0, 0, 'hA5A5, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Scoreboard.
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 1, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 4, 7, 0, 4, 0, 0, 0, 0, 7, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 0, 0, 7, 0, 7, 0, 1));
    tbl.push_back(mk(1, 1, 4, 9, 4, 4, 1, 4, 9, 0, 9, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 0, 0, 9, 1, 9, 1, 1));
    tbl.push_back(mk(1, 1, 4, 'h0A, 4, 0, 0, 0, 'h0A, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 0, 0, 'h0A, 0, 'h0A, 0, 1));
    // Reset mid-operation, then again mid-sweep.
    tbl.push_back(mk(1, 1, 1, 'h55, 1, 2, 1, 2, 'h55, 0, 'hA5A5, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 'h55, 0, 'hA5A5, 1, 1));
    tbl.push_back(mk(0, 1, 1, 'hFFFF, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    repeat (8) tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i], tag);
      chk({tag, " tbl rdA"},   rdA8,       tbl[i].eA);
      chk({tag, " tbl rdB"},   rdB8,       tbl[i].eB);
      chk({tag, " tbl pendA"}, W'(pendA8), W'(tbl[i].ePA));
      chk({tag, " tbl pendB"}, W'(pendB8), W'(tbl[i].ePB));
      chk({tag, " tbl ready"}, W'(ready8), W'(tbl[i].eR));
      step();
    end

    // Out-of-range addresses on the 6-register file (valid on the 8-register).
    drive(mk(1, 1, 7, 'h1111, 7, 6, 0, 0, 0, 0, 0, 0, 0), "oor wr7");
    chk("oor rdA6 ra7", rdA6, '0);
    chk("oor rdB6 ra6", rdB6, '0);
    step();
    drive(mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0), "oor rd7");
    chk("oor rdA6 after wr7", rdA6, '0);
    chk("oor rdB6 r1", rdB6, '0);
    chk("oor rdA8 r7", rdA8, W'('h1111));
    step();
    drive(mk(1, 0, 0, 0, 6, 7, 1, 7, 0, 0, 0, 0, 0), "oor mk7");
    step();
    drive(mk(1, 0, 0, 0, 6, 7, 1, 6, 0, 0, 0, 0, 0), "oor mk6");
    step();
    drive(mk(1, 0, 0, 0, 6, 7, 0, 0, 0, 0, 0, 0, 0), "oor pend");
    chk("oor pendA6 r6", W'(pendA6), '0);
    chk("oor pendB6 r7", W'(pendB6), '0);
    chk("oor rdA6 r6",   rdA6, '0);
    chk("oor pendA8 r6", W'(pendA8), W'(1));
    chk("oor pendB8 r7", W'(pendB8), W'(1));
    step();
    drive(mk(1, 0, 0, 0, 5, 5, 1, 5, 0, 0, 0, 0, 0), "top mk5");
    step();
    drive(mk(1, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 0), "top pend5");
    chk("top pendA6 r5", W'(pendA6), W'(1));
    step();

    // Randomized traffic with occasional resets, model-checked every cycle.
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = mk(($urandom_range(0, 40) != 0), 1'($urandom), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
             0, 0, 0, 0, 0);
      drive(v, $sformatf("rnd%0d", i));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-register file for the pipelined datapath: one write port, two combinational read ports.
- Additions over the fixed 4-entry file:
  - configurable width and depth
  - optional hardwired-zero r0
  - write-to-read bypass
  - per-register pending scoreboard for the hazard/stall logic
  - post-reset clearing sweep that models a RAM-backed array
- Sits between decode (read addresses, mark) and writeback (w/wa/wd).

Parameters:
WIDTH, 16, data width in bits
NREGS, 8, number of implemented registers (2..2**AW)
AW, 3, address width of wa/raA/raB/ma
ZERO_R0, 1, 1 = r0 reads as 0, ignores writes, is never pending

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
w  input  1  write enable
wa  input  AW  write address
wd  input  WIDTH  write data
raA  input  AW  read address A
rdA  output  WIDTH  read data A, combinational
raB  input  AW  read address B
rdB  output  WIDTH  read data B, combinational
mark  input  1  set pending bit of register ma (result now in flight)
ma  input  AW  mark address
pendA  output  1  register raA pending, value not yet valid
pendB  output  1  register raB pending
ready  output  1  1 once clearing sweep complete

Behaviour:
- Reset: rst_n low at a rising edge →
  - FSM = INIT, sweep counter = 0, all pending bits = 0
  - Register contents are not reset directly.
  - While rst_n is low: ready=0, rdA=rdB=0, pendA=pendB=0.
- INIT state:
  - Each cycle writes 0 to reg[counter], then counter increments.
  - After the cycle that writes reg[NREGS-1], FSM = RUN. Sweep takes NREGS cycles from the first edge with rst_n high.
  - w and mark are ignored.
  - ready=0; rdA, rdB, pendA, pendB are forced to 0.
  - rst_n low mid-sweep restarts the sweep at counter 0.
- RUN state (ready=1; terminal until reset):
  - Write: w=1 and wa valid (wa < NREGS, and wa != 0 when ZERO_R0) → reg[wa] <= wd at the edge. Invalid wa → write dropped.
  - Read:
    - rdX = 0 if raX >= NREGS, or if ZERO_R0 and raX == 0.
    - Otherwise, if w and wa == raX and the write is valid → rdX = wd (bypass: same-cycle write is visible).
    - Otherwise rdX = reg[raX].
  - Scoreboard:
    - A valid write to a clears pend[wa] at the edge.
    - mark with valid ma sets pend[ma] at the edge.
    - mark and write to the same address in the same cycle → pending set; the newer producer wins.
    - Invalid ma is ignored.
  - pendX = pend[raX] & ~(w & wa == raX & write valid). Bypassed data counts as available.
  - pendX = 0 for invalid or zero addresses.
- Both read ports are independent; raA == raB is legal and both return identical data.
- No internal registering of outputs: read latency is 0 cycles and write-to-read latency is 0 cycles via bypass.

Test Plan:
- Reset then sweep, NREGS=8:
  - Hold rst_n=0 for 2 cycles, release.
  - ready rises exactly 8 edges later.
  - Every raA 0..7 then reads 0.
  - w=1 during INIT leaves no effect.
- Basic write/read:
  - RUN: write r3=16'hBEEF, r5=16'h1234 on consecutive cycles.
  - Then raA=3 → rdA=BEEF and raB=5 → rdB=1234 simultaneously.
  - raA=raB=3 → both BEEF.
- Bypass and zero register:
  - w=1, wa=2, wd=16'hA5A5 with raA=2 in the same cycle → rdA=A5A5 before the edge.
  - Next cycle rdA remains A5A5.
  - Write wa=0 wd=FFFF → rdA at raA=0 stays 0.
- Scoreboard:
  - mark ma=4 → next cycle raB=4 gives pendB=1.
  - Write r4 wd=7 → pendB=0 and rdB=7 in the write cycle (bypass), and pend cleared after the edge.
  - mark and write r4 in the same cycle → pendB=1 afterward.
- Out-of-range, with NREGS=6, AW=3:
  - Write wa=7 → dropped.
  - raA=6 → rdA=0, pendA=0.
  - mark ma=7 → no effect.
- Reset mid-operation:
  - Set r1=55, mark r2, then rst_n=0 for one edge midway through a later sweep.
  - Sweep restarts with ready low for a full NREGS cycles.
  - Afterward r1 reads 0 and pend of r2 = 0.
